// File: rtl/muldiv_seq_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_seq_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_CNT_W = 5;

    // Operation codes, aligned with the ALU op-code space
    typedef enum logic [1:0] {
        MD_OP_MUL   = 2'd0,
        MD_OP_MULHU = 2'd1,
        MD_OP_DIVU  = 2'd2,
        MD_OP_REMU  = 2'd3
    } md_op_e;

    // Control states of the sequencer
    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_RUN  = 2'd1,
        MD_ST_DONE = 2'd2
    } md_state_e;

    // Divide ops have op[1] set; high-half / remainder results have op[0] set
    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic md_sel_hi(input md_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One iteration of shift-add multiply or restoring divide.
module muldiv_step
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] hi_rem_i,
    input  logic [WIDTH-1:0] lo_quo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_rem_o,
    output logic [WIDTH-1:0] lo_quo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic           fits;

    // Compute next hi/rem and lo/quo for the selected mode
    always_comb begin
        sum      = '0;
        trial    = '0;
        fits     = 1'b0;
        hi_rem_o = hi_rem_i;
        lo_quo_o = lo_quo_i;
        if (div_i) begin
            // Sign of the 34-bit trial subtraction is equivalent to an
            // unsigned compare; when it fits, the difference fits in WIDTH bits.
            trial    = {hi_rem_i, lo_quo_i[WIDTH-1]};
            fits     = (trial >= {1'b0, b_i});
            hi_rem_o = fits ? (trial[WIDTH-1:0] - b_i) : trial[WIDTH-1:0];
            lo_quo_o = {lo_quo_i[WIDTH-2:0], fits};
        end else begin
            sum      = {1'b0, hi_rem_i} + (lo_quo_i[0] ? {1'b0, b_i} : '0);
            hi_rem_o = sum[WIDTH:1];
            lo_quo_o = {sum[0], lo_quo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 32-bit unsigned MUL/MULHU/DIVU/REMU unit with valid/ready channels.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    md_state_e             state_q, state_d;
    md_op_e                op_q;
    logic [MD_CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]      hi_rem_q;
    logic [WIDTH-1:0]      lo_quo_q;
    logic [WIDTH-1:0]      b_q;
    logic [WIDTH-1:0]      rsp_data_q;
    logic                  rsp_valid_q;

    logic [WIDTH-1:0]      step_hi_rem;
    logic [WIDTH-1:0]      step_lo_quo;
    logic                  last_iter;
    logic                  load_en;
    logic                  iter_en;
    logic                  rsp_take;

    assign last_iter = (count_q == MD_CNT_W'(31));

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .div_i    (md_is_div(op_q)),
        .hi_rem_i (hi_rem_q),
        .lo_quo_i (lo_quo_q),
        .b_i      (b_q),
        .hi_rem_o (step_hi_rem),
        .lo_quo_o (step_lo_quo)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = MD_ST_IDLE;
        end else begin
            unique case (state_q)
                MD_ST_IDLE: if (req_valid)               state_d = MD_ST_RUN;
                MD_ST_RUN:  if (last_iter)               state_d = MD_ST_DONE;
                MD_ST_DONE: if (rsp_valid_q && rsp_ready) state_d = MD_ST_IDLE;
                default:                                 state_d = MD_ST_IDLE;
            endcase
        end
    end

    // Handshake outputs and datapath strobes
    always_comb begin
        req_ready = (state_q == MD_ST_IDLE);
        busy      = (state_q != MD_ST_IDLE);
        load_en   = !flush && (state_q == MD_ST_IDLE) && req_valid;
        iter_en   = !flush && (state_q == MD_ST_RUN);
        rsp_take  = (state_q == MD_ST_DONE) && rsp_valid_q && rsp_ready;
    end

    // Operand latch, iteration registers and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= MD_OP_MUL;
            count_q     <= '0;
            hi_rem_q    <= '0;
            lo_quo_q    <= '0;
            b_q         <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else if (flush) begin
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (load_en) begin
                op_q     <= md_op_e'(req_op);
                count_q  <= '0;
                hi_rem_q <= '0;
                lo_quo_q <= req_a;
                b_q      <= req_b;
            end
            if (iter_en) begin
                hi_rem_q <= step_hi_rem;
                lo_quo_q <= step_lo_quo;
                count_q  <= count_q + MD_CNT_W'(1);
                if (last_iter) begin
                    // Final iteration result goes straight into the response
                    rsp_data_q  <= md_sel_hi(op_q) ? step_hi_rem : step_lo_quo;
                    rsp_valid_q <= 1'b1;
                end
            end
            if (rsp_take) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    int unsigned tests_run;
    int unsigned tests_failed;

    localparam logic [1:0] OP_MUL   = 2'd0;
    localparam logic [1:0] OP_MULHU = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_REMU  = 2'd3;

    muldiv_seq #(
        .WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; returns at the negedge after the accept edge
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'hCAFE_F00D;
    endtask

    // Counts cycles from the accept cycle until rsp_valid is seen (bounded)
    task automatic wait_rsp(output int cyc, output logic ready_seen);
        cyc        = 1;
        ready_seen = 1'b0;
        while (!rsp_valid && cyc < 45) begin
            if (req_ready) ready_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int   cyc;
        logic rs;
        check({tag, "_ready_pre"}, {31'd0, req_ready}, 32'd1);
        start_op(op, a, b);
        wait_rsp(cyc, rs);
        check({tag, "_latency"}, cyc, 32'd33);
        check({tag, "_ready_run"}, {31'd0, rs}, 32'd0);
        check({tag, "_data"}, rsp_data, exp);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_idle"}, {30'd0, busy, req_ready}, 32'd1);
    endtask

    initial begin
        int   cyc;
        logic rs;
        logic seen;
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_data",  rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul_7x6",      OP_MUL,   32'd7,          32'd6,          32'd42);
        run_op("mul_ffxff",    OP_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001);
        run_op("mulhu_ffxff",  OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
        run_op("mul_8000x2",   OP_MUL,   32'h8000_0000,  32'd2,          32'd0);
        run_op("mulhu_8000x2", OP_MULHU, 32'h8000_0000,  32'd2,          32'd1);
        run_op("divu_100_7",   OP_DIVU,  32'd100,        32'd7,          32'd14);
        run_op("remu_100_7",   OP_REMU,  32'd100,        32'd7,          32'd2);
        run_op("divu_5_9",     OP_DIVU,  32'd5,          32'd9,          32'd0);
        run_op("remu_5_9",     OP_REMU,  32'd5,          32'd9,          32'd5);
        run_op("divu_ff_1",    OP_DIVU,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF);
        run_op("divu_by0",     OP_DIVU,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF);
        run_op("remu_by0",     OP_REMU,  32'h1234_5678,  32'd0,          32'h1234_5678);

        // Backpressure in DONE with a competing request held on the input
        start_op(OP_DIVU, 32'd100, 32'd7);
        wait_rsp(cyc, rs);
        check("bp_latency", cyc, 32'd33);
        req_op    = OP_MUL;
        req_a     = 32'd3;
        req_b     = 32'd5;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_hold", {31'd0, rsp_valid}, 32'd1);
            check("bp_data_hold",  rsp_data, 32'd14);
            check("bp_ready_low",  {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_release_idle",  {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_next_busy", {31'd0, busy}, 32'd1);
        wait_rsp(cyc, rs);
        check("bp_next_latency", cyc, 32'd33);
        check("bp_next_data", rsp_data, 32'd15);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Flush mid-run at count 10
        start_op(OP_MUL, 32'd7, 32'd6);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy",  {31'd0, busy}, 32'd0);
        check("flush_ready", {31'd0, req_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_no_rsp", {31'd0, seen}, 32'd0);

        // Flush beats a request presented in IDLE
        req_op    = OP_MUL;
        req_a     = 32'd2;
        req_b     = 32'd2;
        req_valid = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_idle_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a run
        start_op(OP_MUL, 32'd9, 32'd9);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, req_ready}, 32'd1);
        check("arst_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_data",  rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("mul_3x5", OP_MUL, 32'd3, 32'd5, 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
